// File: rtl/floo_axis_bridge_pkg.sv
// floo_axis_bridge_pkg: shared types and helpers for the AXIS virtual-channel bridge halves.
package floo_axis_bridge_pkg;
    typedef enum logic {ChanRsp = 1'b0, ChanReq = 1'b1} channel_hdr_e;

    function automatic int credit_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DefaultCredits  = 8;
    localparam int DefaultFlitSize = 64;
    localparam int CreditW         = credit_width(DefaultCredits);

    typedef struct packed {
        logic               data_validity;
        logic               credits_hdr;
        logic [CreditW-1:0] credits;
    } user_bits_t;

    typedef struct packed {
        logic [DefaultFlitSize:0] data;
        user_bits_t               user;
    } axis_t_t;

    typedef struct packed {
        logic    tvalid;
        axis_t_t t;
    } axis_req_t;

    typedef struct packed {
        logic tready;
    } axis_rsp_t;
endpackage

// File: rtl/floo_axis_vc_credit_fifo.sv
// floo_axis_vc_credit_fifo: per-channel flit FIFO with freed-slot credit counter and sticky overflow.
module floo_axis_vc_credit_fifo #(
    parameter int Depth = 8,
    parameter int DataW = 64,
    parameter int CntW  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [DataW-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [DataW-1:0] data_o,
    input  logic             take_i,
    output logic [CntW-1:0]  credit_o,
    output logic             overflow_o
);
    localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;

    logic [DataW-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr, r_rd;
    logic [CntW-1:0]  r_cnt, r_credit;
    logic             r_ovf;
    logic             w_pop, w_full, w_push;

    assign w_pop      = valid_o & ready_i;
    assign w_full     = r_cnt == CntW'(Depth);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = push_i & (!w_full | w_pop);
    assign valid_o    = r_cnt != '0;
    assign data_o     = r_mem[r_rd];
    assign credit_o   = r_credit;
    assign overflow_o = r_ovf;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_credit <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr <= (r_wr == PtrW'(Depth - 1)) ? '0 : r_wr + PtrW'(1);
            if (w_pop) r_rd <= (r_rd == PtrW'(Depth - 1)) ? '0 : r_rd + PtrW'(1);
            r_cnt    <= r_cnt + CntW'(w_push) - CntW'(w_pop);
            r_credit <= take_i ? CntW'(w_pop) : r_credit + CntW'(w_pop);
            r_ovf    <= r_ovf | (push_i & !w_push);
        end
    end
endmodule

// File: rtl/floo_axis_vc_bridge_rx.sv
// floo_axis_vc_bridge_rx: receive half of the credit-based VC AXIS bridge.
// Demuxes beats into request/response FIFOs and forwards peer credits to the TX half.
module floo_axis_vc_bridge_rx #(
    parameter int  NumCredits   = 8,
    parameter int  FlitDataSize = 64,
    parameter type axis_req_t   = floo_axis_bridge_pkg::axis_req_t,
    parameter type axis_rsp_t   = floo_axis_bridge_pkg::axis_rsp_t,
    localparam int CntW         = floo_axis_bridge_pkg::credit_width(NumCredits)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  axis_req_t               axis_in_req_i,
    output axis_rsp_t               axis_in_rsp_o,
    output logic                    req_valid_o,
    input  logic                    req_ready_i,
    output logic [FlitDataSize-1:0] req_data_o,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [FlitDataSize-1:0] rsp_data_o,
    output logic                    rx_credit_valid_o,
    output logic                    rx_credit_chan_o,
    output logic [CntW-1:0]         rx_credit_cnt_o,
    output logic [CntW-1:0]         ret_credit_req_o,
    output logic [CntW-1:0]         ret_credit_rsp_o,
    input  logic [1:0]              ret_credit_take_i,
    output logic                    overflow_o
);
    import floo_axis_bridge_pkg::*;

    logic                    w_beat, w_is_req, w_push_req, w_push_rsp, w_cred;
    logic                    w_ovf_req, w_ovf_rsp;
    logic [FlitDataSize-1:0] w_flit;
    logic                    r_cred_valid, r_cred_chan;
    logic [CntW-1:0]         r_cred_cnt;

    always_comb begin
        axis_in_rsp_o        = '0;
        axis_in_rsp_o.tready = !rst_i;
    end

    assign w_beat     = axis_in_req_i.tvalid & !rst_i;
    assign w_is_req   = channel_hdr_e'(axis_in_req_i.t.data[FlitDataSize]) == ChanReq;
    assign w_flit     = axis_in_req_i.t.data[FlitDataSize-1:0];
    assign w_push_req = w_beat & axis_in_req_i.t.user.data_validity & w_is_req;
    assign w_push_rsp = w_beat & axis_in_req_i.t.user.data_validity & !w_is_req;
    assign w_cred     = w_beat & (axis_in_req_i.t.user.credits != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cred_valid <= 1'b0;
            r_cred_chan  <= 1'b0;
            r_cred_cnt   <= '0;
        end else begin
            r_cred_valid <= w_cred;
            if (w_cred) begin
                r_cred_chan <= axis_in_req_i.t.user.credits_hdr;
                r_cred_cnt  <= CntW'(axis_in_req_i.t.user.credits);
            end
        end
    end

    assign rx_credit_valid_o = r_cred_valid;
    assign rx_credit_chan_o  = r_cred_chan;
    assign rx_credit_cnt_o   = r_cred_cnt;
    assign overflow_o        = w_ovf_req | w_ovf_rsp;

    floo_axis_vc_credit_fifo #(.Depth(NumCredits), .DataW(FlitDataSize), .CntW(CntW)) i_req_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_push_req),
        .data_i     (w_flit),
        .valid_o    (req_valid_o),
        .ready_i    (req_ready_i),
        .data_o     (req_data_o),
        .take_i     (ret_credit_take_i[1]),
        .credit_o   (ret_credit_req_o),
        .overflow_o (w_ovf_req)
    );

    floo_axis_vc_credit_fifo #(.Depth(NumCredits), .DataW(FlitDataSize), .CntW(CntW)) i_rsp_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_push_rsp),
        .data_i     (w_flit),
        .valid_o    (rsp_valid_o),
        .ready_i    (rsp_ready_i),
        .data_o     (rsp_data_o),
        .take_i     (ret_credit_take_i[0]),
        .credit_o   (ret_credit_rsp_o),
        .overflow_o (w_ovf_rsp)
    );
endmodule

// File: doc/floo_axis_vc_bridge_rx.md
# floo_axis_vc_bridge_rx

Receive half of the credit-based virtual-channel AXI-Stream NoC bridge. It accepts AXIS beats from the remote bridge and demultiplexes them by header bit into per-channel request and response FIFOs, each sized to the credit count. Buffered flits drain onto local NoC request/response handshake ports. The block hands credits received from the peer to the local transmit half, and accumulates freed-slot credits for the transmit half to send back.

## Interface
- `NumCredits`, 8: credits per virtual channel, equal to the depth of each channel FIFO; must be ≥1.
- `FlitDataSize`, 64: flit payload width, excluding valid/ready.
- `axis_req_t`, –: AXIS request struct (`tvalid`, `t.data`, `t.user`); `t.data` ≥ FlitDataSize+1 bits.
- `axis_rsp_t`, –: AXIS response struct (`tready`).
- Derived: `CntW = $clog2(NumCredits+1)`.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `axis_in_req_i` in axis_req_t: beats from the remote bridge.
- `axis_in_rsp_o` out axis_rsp_t: `tready`.
- `req_valid_o` / `req_ready_i` / `req_data_o`: out 1 / in 1 / out FlitDataSize. Request flit to the NoC.
- `rsp_valid_o` / `rsp_ready_i` / `rsp_data_o`: out 1 / in 1 / out FlitDataSize. Response flit to the NoC.
- `rx_credit_valid_o` out 1: one-cycle pulse carrying credits granted by the peer.
- `rx_credit_chan_o` out 1: channel of those credits; 1 = request, 0 = response.
- `rx_credit_cnt_o` out CntW: number of credits granted.
- `ret_credit_req_o` / `ret_credit_rsp_o` out CntW: credits pending return, per channel.
- `ret_credit_take_i` in 2: bit1 = request, bit0 = response. The TX half consumed the full displayed count this cycle.
- `overflow_o` out 1: sticky protocol error.

## Operation
- **Beat decode.** A beat is accepted when `tvalid & tready`. `tready` is 1 in every cycle except during reset.
- **Data.** If `t.user.data_validity = 1`, `t.data[FlitDataSize]` selects the channel (1 = request, 0 = response) and `t.data[FlitDataSize-1:0]` is pushed into that channel's FIFO.
- **Credits.** If `t.user.credits ≠ 0`, independent of `data_validity`, the block registers a pulse next cycle: `rx_credit_valid_o = 1`, `rx_credit_chan_o = t.user.credits_hdr`, `rx_credit_cnt_o = t.user.credits`.
- **FIFOs.** One FIFO per channel, depth NumCredits. `*_valid_o = !empty`; `*_data_o` = head entry. A pop occurs on `valid & ready`.
- **Credit return.** Each pop increments that channel's return counter. When `take` is set, the counter becomes the pop for that cycle (0 or 1); the displayed value has been consumed. The counter never exceeds NumCredits, so no saturation logic is needed.
- **Overflow.** A push into a full FIFO with no same-cycle pop drops the flit and sets `overflow_o`, which holds until reset. A push into a full FIFO with a same-cycle pop is legal.
- **Independence.** The two channels are fully independent. A stalled `rsp_ready_i` never blocks request traffic.

## Timing
- **Reset values.** All outputs are 0 during and after reset: `tready = 0`, both FIFOs empty, both return counters 0, `overflow_o = 0`, no credit pulse. `tready` rises in the first cycle after `rst_i` deasserts.
- **Push to valid.** A flit accepted at edge n shows `*_valid_o` in cycle n+1. There is no combinational path from AXIS to the NoC outputs.
- **Pop to credit.** A pop at edge n raises `ret_credit_*_o` in cycle n+1.
- **Credit pulse.** `rx_credit_*` is registered and valid exactly one cycle after the carrying beat.
- **Reset mid-operation.** FIFO contents and pending credits are discarded. The peer bridge must be reset in the same window.
- **Full FIFO with push and pop at the same edge.** Occupancy stays at NumCredits. Head and tail pointers wrap modulo NumCredits.

## Structure
- **Package `floo_axis_bridge_pkg`** holds:
  - `channel_hdr_e` (response = 0, request = 1);
  - `user_bits_t` {`data_validity`, `credits_hdr`, `credits`};
  - a `credit_width(n)` function shared with the TX half.
- **Sub-module `floo_axis_vc_credit_fifo`**, instantiated twice. Each instance contains:
  - a FIFO of depth NumCredits with synchronous active-high reset;
  - the return-credit counter;
  - the per-channel overflow detection.

## Test plan
- **Reset release.** Hold `rst_i` for 5 cycles, then release. `tready = 0` during reset and 1 on the next cycle; all other outputs are 0.
- **Request flit.** Beat with `data_validity = 1`, hdr = 1, data = 0xA5 → `req_valid_o = 1`, `req_data_o = 0xA5` one cycle later; `rsp_valid_o` stays 0. Pop it → `ret_credit_req_o = 1`. Assert take → 0 next cycle.
- **Fill and drain.** Eight response beats with `rsp_ready_i = 0` → all accepted, `overflow_o = 0`. A ninth beat → `overflow_o = 1` and the flit is dropped. Drain → `ret_credit_rsp_o` counts up to 8.
- **Credit-only beat.** `data_validity = 0`, `credits_hdr = 1`, `credits = 5` → one-cycle pulse with chan = 1, cnt = 5. No FIFO push occurs.
- **Channel isolation.** `rsp_ready_i = 0` with a full response FIFO while request flits stream → request flits pass at one per cycle and keep their order.
- **Take during pop.** Counter shows 3, `take` and a pop coincide → counter reads 1 next cycle.
